// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// rtl/uart_rx_pkt_ctrl_pkg.sv - shared types and constants for the UART packet controller.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    DISCARD
  } state_t;

  localparam logic [2:0] ERR_CHK = 3'd1;
  localparam logic [2:0] ERR_LEN = 3'd2;
  localparam logic [2:0] ERR_OVF = 3'd3;
  localparam logic [2:0] ERR_BRK = 3'd4;
  localparam logic [2:0] ERR_TMO = 3'd5;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_pkt_ctrl_if.sv
// rtl/uart_rx_pkt_ctrl_if.sv - committed payload byte stream with valid/ready/last handshake.
interface uart_rx_pkt_ctrl_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/uart_rx_pkt_ctrl_fifo.sv
// rtl/uart_rx_pkt_ctrl_fifo.sv - 9-bit FIFO with speculative write pointer, commit and rollback.
module uart_pkt_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [8:0]             wr_data,
  input  logic                   commit,
  input  logic                   rollback,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [8:0]             rd_data,
  output logic [$clog2(DEPTH):0] free,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_spec;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;

  // Only committed entries are readable; speculative ones sit between commit_ptr and wr_spec.
  assign rd_valid = (rd_ptr != commit_ptr);
  assign rd_data  = mem[rd_ptr[PW-2:0]];
  assign free     = PW'(DEPTH) - (wr_spec - rd_ptr);
  assign level    = commit_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_spec    <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (rollback) begin
        wr_spec <= commit_ptr;
      end else if (wr_en) begin
        wr_spec <= wr_spec + 1'b1;
      end
      if (commit) begin
        commit_ptr <= wr_spec;
      end
      if (rd_en && rd_valid) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_spec[PW-2:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - SOF/LEN/payload/CHK packet parser releasing only checksum-good payloads.
// Optional inter-byte timeout enabled by defining UART_RX_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int         DEPTH          = 64,
  parameter int         MAX_LEN        = 32,
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rx_en,
  output logic                   uart_rx_en,
  input  logic                   uart_rx_valid,
  input  logic                   uart_rx_break,
  input  logic [7:0]             uart_rx_data,
  uart_rx_pkt_ctrl_if.master     stream,
  output logic                   pkt_ok,
  output logic                   pkt_err,
  output logic [2:0]             err_code,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int PW = $clog2(DEPTH) + 1;

  state_t        state, state_nxt;
  logic [7:0]    sum, sum_nxt, chk_sum;
  logic [8:0]    cnt, cnt_nxt;
  logic          ok_nxt, err_nxt;
  logic [2:0]    code_nxt;
  logic          fifo_wr, fifo_commit, fifo_rollback;
  logic [PW-1:0] fifo_free;
  logic [8:0]    fifo_rd_data;
  logic          byte_ev, brk_ev;

  assign uart_rx_en = rx_en;
  assign byte_ev    = rx_en && uart_rx_valid && !uart_rx_break;
  assign brk_ev     = rx_en && uart_rx_valid && uart_rx_break;
  assign chk_sum    = sum + uart_rx_data;

  uart_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (fifo_wr),
    .wr_data  ({cnt == 9'd1, uart_rx_data}),
    .commit   (fifo_commit),
    .rollback (fifo_rollback),
    .rd_en    (stream.m_ready),
    .rd_valid (stream.m_valid),
    .rd_data  (fifo_rd_data),
    .free     (fifo_free),
    .level    (fifo_level)
  );

  assign stream.m_data = fifo_rd_data[7:0];
  assign stream.m_last = fifo_rd_data[8];

`ifdef UART_RX_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = rx_en && !uart_rx_valid && (state != IDLE) &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles inside a frame; frozen while rx_en is low.
  always_ff @(posedge clk) begin
    if (!resetn || state == IDLE || tmo_hit || (rx_en && uart_rx_valid)) begin
      tmo_cnt <= '0;
    end else if (rx_en) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    sum_nxt       = sum;
    cnt_nxt       = cnt;
    fifo_wr       = 1'b0;
    fifo_commit   = 1'b0;
    fifo_rollback = 1'b0;
    ok_nxt        = 1'b0;
    err_nxt       = 1'b0;
    code_nxt      = err_code;
    if (brk_ev && state != IDLE) begin
      fifo_rollback = 1'b1;
      err_nxt       = 1'b1;
      code_nxt      = ERR_BRK;
      state_nxt     = IDLE;
    end else if (byte_ev) begin
      case (state)
        IDLE: begin
          if (uart_rx_data == SOF_BYTE) state_nxt = LEN;
        end
        LEN: begin
          if (uart_rx_data == 8'd0 || 32'(uart_rx_data) > MAX_LEN) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_LEN;
            state_nxt = IDLE;
          end else if (32'(fifo_free) < 32'(uart_rx_data)) begin
            // Swallow payload plus checksum so they are not mistaken for a new SOF.
            err_nxt   = 1'b1;
            code_nxt  = ERR_OVF;
            cnt_nxt   = {1'b0, uart_rx_data} + 9'd1;
            state_nxt = DISCARD;
          end else begin
            sum_nxt   = uart_rx_data;
            cnt_nxt   = {1'b0, uart_rx_data};
            state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          fifo_wr = 1'b1;
          sum_nxt = chk_sum;
          cnt_nxt = cnt - 9'd1;
          if (cnt == 9'd1) state_nxt = CHK;
        end
        CHK: begin
          if (chk_sum == 8'd0) begin
            fifo_commit = 1'b1;
            ok_nxt      = 1'b1;
          end else begin
            fifo_rollback = 1'b1;
            err_nxt       = 1'b1;
            code_nxt      = ERR_CHK;
          end
          state_nxt = IDLE;
        end
        DISCARD: begin
          cnt_nxt = cnt - 9'd1;
          if (cnt == 9'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
`ifdef UART_RX_PKT_TIMEOUT_EN
    end else if (tmo_hit) begin
      fifo_rollback = 1'b1;
      err_nxt       = 1'b1;
      code_nxt      = ERR_TMO;
      state_nxt     = IDLE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      sum      <= '0;
      cnt      <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= '0;
    end else begin
      state    <= state_nxt;
      sum      <= sum_nxt;
      cnt      <= cnt_nxt;
      pkt_ok   <= ok_nxt;
      pkt_err  <= err_nxt;
      err_code <= code_nxt;
    end
  end

endmodule
